// File: rtl/trap_seq.sv
// Machine-mode trap entry / MRET sequencer driving the CSR file's single write port.
// Optional build macro TRAP_VECTORED_EN enables vectored interrupt targets from mtvec_in.
module trap_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        ready,
  output logic        csr_w_en,
  output logic [11:0] csr_w_addr,
  output logic [31:0] csr_w_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  priv_mode
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_TVAL   = 3'd3,
    W_STATUS = 3'd4,
    M_STATUS = 3'd5,
    REDIRECT = 3'd6
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [1:0]  PRIV_M      = 2'b11;
  localparam logic [1:0]  PRIV_U      = 2'b00;

  state_t      state_r;
  logic [31:0] cause_r;
  logic [31:0] tval_r;
  logic [31:0] epc_r;
  logic [31:0] status_r;
  logic [1:0]  tgt_priv_r;
  logic        is_mret_r;

  logic        trap_take_s;
  logic        mret_take_s;

  // MPIE <= MIE, MIE <= 0, MPP <= current privilege
  function automatic logic [31:0] trap_status(input logic [31:0] st, input logic [1:0] priv);
    logic [31:0] r;
    r       = st;
    r[7]    = st[3];
    r[3]    = 1'b0;
    r[12:11] = priv;
    return r;
  endfunction

  // MIE <= MPIE, MPIE <= 1, MPP <= U
  function automatic logic [31:0] mret_status(input logic [31:0] st);
    logic [31:0] r;
    r        = st;
    r[3]     = st[7];
    r[7]     = 1'b1;
    r[12:11] = PRIV_U;
    return r;
  endfunction

  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if ((tvec[1:0] == 2'b01) && cause[31]) begin
      return base + {cause[29:0], 2'b00};
    end else begin
      return base;
    end
`else
    return base;
`endif
  endfunction

  // An MRET outside M mode becomes an illegal-instruction trap; a real trap always wins.
  assign trap_take_s = trap_valid || (mret_valid && (priv_mode != PRIV_M));
  assign mret_take_s = mret_valid && !trap_valid && (priv_mode == PRIV_M);

  // Sequencer state, latched trap context and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      cause_r        <= 32'd0;
      tval_r         <= 32'd0;
      epc_r          <= 32'd0;
      status_r       <= 32'd0;
      tgt_priv_r     <= PRIV_M;
      is_mret_r      <= 1'b0;
      ready          <= 1'b1;
      csr_w_en       <= 1'b0;
      csr_w_addr     <= 12'd0;
      csr_w_data     <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      priv_mode      <= PRIV_M;
    end else begin
      case (state_r)
        IDLE: begin
          if (trap_take_s) begin
            cause_r    <= trap_valid ? trap_cause : 32'd2;
            tval_r     <= trap_valid ? trap_tval : 32'd0;
            epc_r      <= {trap_pc[31:2], 2'b00};
            status_r   <= trap_status(mstatus_in, priv_mode);
            tgt_priv_r <= PRIV_M;
            is_mret_r  <= 1'b0;
            priv_mode  <= PRIV_M;
            ready      <= 1'b0;
            csr_w_en   <= 1'b1;
            csr_w_addr <= CSR_MEPC;
            csr_w_data <= {trap_pc[31:2], 2'b00};
            state_r    <= W_EPC;
          end else if (mret_take_s) begin
            epc_r      <= mepc_in;
            status_r   <= mret_status(mstatus_in);
            tgt_priv_r <= mstatus_in[12:11];
            is_mret_r  <= 1'b1;
            ready      <= 1'b0;
            csr_w_en   <= 1'b1;
            csr_w_addr <= CSR_MSTATUS;
            csr_w_data <= mret_status(mstatus_in);
            state_r    <= M_STATUS;
          end else begin
            ready      <= 1'b1;
            csr_w_en   <= 1'b0;
            csr_w_addr <= 12'd0;
            csr_w_data <= 32'd0;
            state_r    <= IDLE;
          end
        end
        W_EPC: begin
          csr_w_addr <= CSR_MCAUSE;
          csr_w_data <= cause_r;
          state_r    <= W_CAUSE;
        end
        W_CAUSE: begin
          csr_w_addr <= CSR_MTVAL;
          csr_w_data <= tval_r;
          state_r    <= W_TVAL;
        end
        W_TVAL: begin
          csr_w_addr <= CSR_MSTATUS;
          csr_w_data <= status_r;
          state_r    <= W_STATUS;
        end
        W_STATUS, M_STATUS: begin
          csr_w_en       <= 1'b0;
          csr_w_addr     <= 12'd0;
          csr_w_data     <= 32'd0;
          redirect_valid <= 1'b1;
          redirect_pc    <= is_mret_r ? epc_r : trap_target(mtvec_in, cause_r);
          state_r        <= REDIRECT;
        end
        REDIRECT: begin
          redirect_valid <= 1'b0;
          redirect_pc    <= 32'd0;
          priv_mode      <= tgt_priv_r;
          ready          <= 1'b1;
          state_r        <= IDLE;
        end
        default: begin
          state_r        <= IDLE;
          ready          <= 1'b1;
          csr_w_en       <= 1'b0;
          csr_w_addr     <= 12'd0;
          csr_w_data     <= 32'd0;
          redirect_valid <= 1'b0;
          redirect_pc    <= 32'd0;
          priv_mode      <= PRIV_M;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed self-checking bench for trap_seq; expected values are hand-computed.
module tb_trap_seq;

  logic        clk;
  logic        rst;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic [31:0] mstatus_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        ready;
  logic        csr_w_en;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  priv_mode;

  int n_checks = 0;
  int n_errors = 0;

  trap_seq dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .ready(ready), .csr_w_en(csr_w_en), .csr_w_addr(csr_w_addr), .csr_w_data(csr_w_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .priv_mode(priv_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
    chk({tag, "_en"},   {31'd0, csr_w_en}, 32'd1);
    chk({tag, "_addr"}, {20'd0, csr_w_addr}, {20'd0, addr});
    chk({tag, "_data"}, csr_w_data, data);
  endtask

  // Call with a trap (or U-mode MRET) request driven while idle; checks the full entry sequence.
  task automatic run_trap(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] status, input logic [31:0] target);
    tick();
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    chk({tag, "_priv_t1"}, {30'd0, priv_mode}, 32'h3);
    chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
    chk_write({tag, "_mepc"}, 12'h341, epc);
    tick();
    chk_write({tag, "_mcause"}, 12'h342, cause);
    tick();
    chk_write({tag, "_mtval"}, 12'h343, tval);
    tick();
    chk_write({tag, "_mstatus"}, 12'h300, status);
    tick();
    chk({tag, "_wen_redir"}, {31'd0, csr_w_en}, 32'd0);
    chk({tag, "_redir_v"}, {31'd0, redirect_valid}, 32'd1);
    chk({tag, "_redir_pc"}, redirect_pc, target);
    tick();
    chk({tag, "_redir_end"}, {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_priv_end"}, {30'd0, priv_mode}, 32'h3);
  endtask

  // Call with an M-mode MRET driven while idle.
  task automatic run_mret(input string tag, input logic [31:0] status, input logic [31:0] target,
                          input logic [1:0] priv);
    tick();
    mret_valid = 1'b0;
    chk_write({tag, "_mstatus"}, 12'h300, status);
    tick();
    chk({tag, "_wen_redir"}, {31'd0, csr_w_en}, 32'd0);
    chk({tag, "_redir_v"}, {31'd0, redirect_valid}, 32'd1);
    chk({tag, "_redir_pc"}, redirect_pc, target);
    chk({tag, "_priv_hold"}, {30'd0, priv_mode}, 32'h3);
    tick();
    chk({tag, "_priv"}, {30'd0, priv_mode}, {30'd0, priv});
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_redir_end"}, {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        saw_redir;
    logic [31:0] vec_target;
    rst = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0;
    trap_cause = 32'd0; trap_pc = 32'd0; trap_tval = 32'd0;
    mstatus_in = 32'd0; mtvec_in = 32'h8000_0100; mepc_in = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset values then five idle cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_wen", {31'd0, csr_w_en}, 32'd0);
      chk("idle_waddr", {20'd0, csr_w_addr}, 32'd0);
      chk("idle_redir", {31'd0, redirect_valid}, 32'd0);
      chk("idle_priv", {30'd0, priv_mode}, 32'h3);
    end

    // MRET with MPP=00 drops to U mode
    mstatus_in = 32'h0000_0000; mepc_in = 32'h0000_3000; mret_valid = 1'b1;
    run_mret("mret_to_u", 32'h0000_0080, 32'h0000_3000, 2'b00);

    // Trap from U mode
    mstatus_in = 32'h0000_0008; mtvec_in = 32'h8000_0100;
    trap_cause = 32'h8; trap_pc = 32'h1006; trap_tval = 32'h0; trap_valid = 1'b1;
    run_trap("trap_u", 32'h1004, 32'h8, 32'h0, 32'h0000_0080, 32'h8000_0100);

    // M-mode MRET: MIE <= MPIE(1), MPIE <= 1, MPP <= 00
    mstatus_in = 32'h0000_1880; mepc_in = 32'h0000_2000; mret_valid = 1'b1;
    run_mret("mret_m", 32'h0000_0088, 32'h0000_2000, 2'b11);

    // Back to U, then MRET in U mode becomes an illegal-instruction trap
    mstatus_in = 32'h0000_0000; mepc_in = 32'h0000_3000; mret_valid = 1'b1;
    run_mret("mret_to_u2", 32'h0000_0080, 32'h0000_3000, 2'b00);
    chk("u_mode", {30'd0, priv_mode}, 32'h0);
    trap_pc = 32'h4008; trap_cause = 32'h55; trap_tval = 32'h1234; mret_valid = 1'b1;
    run_trap("mret_illegal", 32'h4008, 32'h2, 32'h0, 32'h0000_0000, 32'h8000_0100);

    // Simultaneous trap and MRET in M mode: trap wins; vectored target when enabled
`ifdef TRAP_VECTORED_EN
    vec_target = 32'h8000_001C;
`else
    vec_target = 32'h8000_0000;
`endif
    mstatus_in = 32'h0000_0008; mtvec_in = 32'h8000_0001; mepc_in = 32'h0000_2000;
    trap_cause = 32'h8000_0007; trap_pc = 32'h5000; trap_tval = 32'hDEAD;
    trap_valid = 1'b1; mret_valid = 1'b1;
    run_trap("trap_win", 32'h5000, 32'h8000_0007, 32'hDEAD, 32'h0000_1880, vec_target);

    // Reset while in W_TVAL
    mtvec_in = 32'h8000_0100; trap_cause = 32'h3; trap_pc = 32'h6000; trap_tval = 32'h0;
    trap_valid = 1'b1;
    tick();
    trap_valid = 1'b0;
    tick();
    tick();
    chk_write("pre_rst_mtval", 12'h343, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wen", {31'd0, csr_w_en}, 32'd0);
    chk("rst_wdata", csr_w_data, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_priv", {30'd0, priv_mode}, 32'h3);
    chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
    saw_redir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (redirect_valid || csr_w_en) saw_redir = 1'b1;
    end
    chk("rst_no_activity", {31'd0, saw_redir}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
